// File: rtl/defines_cache.sv
// Shared definitions for the dcache miss/uncached AXI bridge: FSM and request
// encodings, AXI size/burst/response constants, cache line geometry.
package defines_cache;

  localparam int CACHE_LINE_WORDS = 8;
  localparam int CACHE_LINE_W     = 256;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    K_UC_RD   = 2'd0,
    K_UC_WR   = 2'd1,
    K_LINE_RD = 2'd2,
    K_LINE_WR = 2'd3
  } kind_e;

  function automatic logic resp_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/dcache_axi_line_buf.sv
// Cache-line register with a saturating beat index, word write port and a
// word read mux; used both to assemble refills and to serve line-write beats.
module dcache_axi_line_buf #(
  parameter int WORDS = 8,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORDS*32-1:0]   load_line,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [31:0]           wr_word,
  input  logic                  adv,
  input  logic [IDX_W-1:0]      rd_sel,
  output logic [WORDS*32-1:0]   line,
  output logic [31:0]           rd_word,
  output logic [IDX_W-1:0]      idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Line storage and beat index; clr only rewinds the index so old data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
      idx  <= '0;
    end else if (load) begin
      line <= load_line;
      idx  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (wr) begin
      line[{idx, 5'b00000} +: 32] <= wr_word;
      if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
    end else if (adv) begin
      if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
    end
  end

  assign rd_word = line[{rd_sel, 5'b00000} +: 32];

endmodule

// File: rtl/dcache_axi_bridge.sv
// AXI4 master for dcache stage-2 misses: line refill, uncached read/write and
// line write, one transaction at a time, with completion pulses and read data.
module dcache_axi_bridge
  import defines_cache::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         LINE_WORDS = 8,
  parameter int         ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_rreq_i,
  input  logic                     line_wreq_i,
  input  logic                     uc_rreq_i,
  input  logic                     uc_wreq_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [3:0]               wen_i,
  input  logic [31:0]              uc_wdata_i,
  input  logic [LINE_WORDS*32-1:0] line_wdata_i,
  output logic                     line_rend_o,
  output logic                     uc_rend_o,
  output logic                     wend_o,
  output logic [LINE_WORDS*32-1:0] line_rdata_o,
  output logic [31:0]              uc_rdata_o,
  output logic                     bus_err_o,
  output logic                     busy_o,
  output logic [3:0]               arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int               IDX_W    = $clog2(LINE_WORDS);
  localparam logic [7:0]       LINE_LEN = 8'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_e      state_r;
  kind_e       kind_r;
  kind_e       req_kind_s;
  logic        req_any_s;
  logic [3:0]  wen_r;
  logic [31:0] uc_wdata_r;
  logic        err_r;

  logic             r_clr_s, r_wr_s, w_load_s, w_adv_s;
  logic [IDX_W-1:0] r_idx_s, w_idx_s, w_sel_s;
  logic [31:0]      r_word_s, w_word_s;
  logic [LINE_WORDS*32-1:0] w_line_s;
  logic             unused_s;

  assign arid     = AXI_ID;
  assign awid     = AXI_ID;
  assign arsize   = SIZE_4B;
  assign awsize   = SIZE_4B;
  assign arburst  = BURST_INCR;
  assign awburst  = BURST_INCR;
  assign unused_s = ^{rid, r_idx_s, r_word_s, w_line_s};

  // Fixed-priority request pick: uc read > uc write > line refill > line write.
  always_comb begin
    req_any_s  = uc_rreq_i | uc_wreq_i | line_rreq_i | line_wreq_i;
    req_kind_s = K_UC_RD;
    if (uc_rreq_i)        req_kind_s = K_UC_RD;
    else if (uc_wreq_i)   req_kind_s = K_UC_WR;
    else if (line_rreq_i) req_kind_s = K_LINE_RD;
    else                  req_kind_s = K_LINE_WR;
  end

  // Line buffer strobes and next-beat select for line writes.
  always_comb begin
    r_clr_s  = (state_r == ST_IDLE) && req_any_s && (req_kind_s == K_LINE_RD);
    w_load_s = (state_r == ST_IDLE) && req_any_s && (req_kind_s == K_LINE_WR);
    r_wr_s   = (state_r == ST_R) && rvalid && (kind_r == K_LINE_RD);
    w_adv_s  = (state_r == ST_W) && wvalid && wready && !wlast && (kind_r == K_LINE_WR);
    if (state_r == ST_W) w_sel_s = w_idx_s + IDX_W'(1);
    else                 w_sel_s = '0;
  end

  dcache_axi_line_buf #(.WORDS(LINE_WORDS)) u_rbuf (
    .clk(clk), .rst(rst),
    .load(1'b0), .load_line('0),
    .clr(r_clr_s), .wr(r_wr_s), .wr_word(rdata), .adv(1'b0),
    .rd_sel('0), .line(line_rdata_o), .rd_word(r_word_s), .idx(r_idx_s)
  );

  dcache_axi_line_buf #(.WORDS(LINE_WORDS)) u_wbuf (
    .clk(clk), .rst(rst),
    .load(w_load_s), .load_line(line_wdata_i),
    .clr(1'b0), .wr(1'b0), .wr_word(32'h0000_0000), .adv(w_adv_s),
    .rd_sel(w_sel_s), .line(w_line_s), .rd_word(w_word_s), .idx(w_idx_s)
  );

  // Transaction FSM; all AXI handshake outputs and end pulses are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      kind_r      <= K_UC_RD;
      wen_r       <= 4'h0;
      uc_wdata_r  <= 32'h0000_0000;
      err_r       <= 1'b0;
      busy_o      <= 1'b0;
      line_rend_o <= 1'b0;
      uc_rend_o   <= 1'b0;
      wend_o      <= 1'b0;
      bus_err_o   <= 1'b0;
      uc_rdata_o  <= 32'h0000_0000;
      araddr      <= '0;
      arlen       <= 8'h00;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awaddr      <= '0;
      awlen       <= 8'h00;
      awvalid     <= 1'b0;
      wdata       <= 32'h0000_0000;
      wstrb       <= 4'h0;
      wlast       <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
    end else begin
      line_rend_o <= 1'b0;
      uc_rend_o   <= 1'b0;
      wend_o      <= 1'b0;
      bus_err_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            kind_r     <= req_kind_s;
            wen_r      <= wen_i;
            uc_wdata_r <= uc_wdata_i;
            err_r      <= 1'b0;
            busy_o     <= 1'b1;
            if (req_kind_s == K_UC_RD || req_kind_s == K_LINE_RD) begin
              state_r <= ST_AR;
              arvalid <= 1'b1;
              araddr  <= addr_i;
              arlen   <= (req_kind_s == K_LINE_RD) ? LINE_LEN : 8'h00;
            end else begin
              state_r <= ST_AW;
              awvalid <= 1'b1;
              awaddr  <= addr_i;
              awlen   <= (req_kind_s == K_LINE_WR) ? LINE_LEN : 8'h00;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            if (kind_r == K_UC_RD) uc_rdata_o <= rdata;
            if (rlast) begin
              rready      <= 1'b0;
              line_rend_o <= (kind_r == K_LINE_RD);
              uc_rend_o   <= (kind_r == K_UC_RD);
              bus_err_o   <= err_r | resp_err(rresp);
              state_r     <= ST_DONE;
            end else begin
              err_r <= err_r | resp_err(rresp);
            end
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            state_r <= ST_W;
            if (kind_r == K_LINE_WR) begin
              wdata <= w_word_s;
              wstrb <= 4'hF;
              wlast <= (LAST_IDX == '0);
            end else begin
              wdata <= uc_wdata_r;
              wstrb <= wen_r;
              wlast <= 1'b1;
            end
          end
        end
        ST_W: begin
          if (wready) begin
            if (wlast) begin
              wvalid  <= 1'b0;
              wlast   <= 1'b0;
              bready  <= 1'b1;
              state_r <= ST_B;
            end else begin
              wdata <= w_word_s;
              wlast <= (w_sel_s == LAST_IDX);
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready    <= 1'b0;
            wend_o    <= 1'b1;
            bus_err_o <= err_r | resp_err(bresp);
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          arvalid <= 1'b0;
          rready  <= 1'b0;
          awvalid <= 1'b0;
          wvalid  <= 1'b0;
          bready  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: the testbench plays the AXI slave by hand.
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_rreq_i = 1'b0, line_wreq_i = 1'b0, uc_rreq_i = 1'b0, uc_wreq_i = 1'b0;
  logic [31:0]  addr_i = 32'h0;
  logic [3:0]   wen_i = 4'h0;
  logic [31:0]  uc_wdata_i = 32'h0;
  logic [255:0] line_wdata_i = 256'h0;
  logic         line_rend_o, uc_rend_o, wend_o, bus_err_o, busy_o;
  logic [255:0] line_rdata_o;
  logic [31:0]  uc_rdata_o;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, awvalid, rready, wvalid, wlast, bready;
  logic         arready = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]   rid = 4'h1;
  logic [31:0]  rdata = 32'h0;
  logic [1:0]   rresp = 2'b00, bresp = 2'b00;
  logic         rlast = 1'b0, rvalid = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  dcache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .line_rreq_i(line_rreq_i), .line_wreq_i(line_wreq_i),
    .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i),
    .addr_i(addr_i), .wen_i(wen_i), .uc_wdata_i(uc_wdata_i), .line_wdata_i(line_wdata_i),
    .line_rend_o(line_rend_o), .uc_rend_o(uc_rend_o), .wend_o(wend_o),
    .line_rdata_o(line_rdata_o), .uc_rdata_o(uc_rdata_o),
    .bus_err_o(bus_err_o), .busy_o(busy_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (arvalid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_aw(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (awvalid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ar_accept();
    arready = 1'b1; tick(); arready = 1'b0;
  endtask

  task automatic aw_accept();
    awready = 1'b1; tick(); awready = 1'b0;
  endtask

  task automatic r_beats(input logic [31:0] base, input int n, input bit last, input logic [1:0] resp);
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rresp  = resp;
      rlast  = last && (k == n - 1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_checks++;
    if ({arvalid, awvalid, rready, wvalid, bready, busy_o} !== 6'b0)
      $display("FAIL reset_handshake: got %b required 000000", {arvalid, awvalid, rready, wvalid, bready, busy_o});
    else n_pass++;
    n_checks++;
    if ({line_rend_o, uc_rend_o, wend_o, bus_err_o} !== 4'b0)
      $display("FAIL reset_pulses: got %b required 0000", {line_rend_o, uc_rend_o, wend_o, bus_err_o});
    else n_pass++;
    n_checks++;
    if (line_rdata_o !== 256'h0 || uc_rdata_o !== 32'h0)
      $display("FAIL reset_data: got line %h uc %h required 0", line_rdata_o, uc_rdata_o);
    else n_pass++;
    rst = 1'b0; tick();
  endtask

  task automatic test_line_refill();
    bit ok;
    line_rreq_i = 1'b1; addr_i = 32'h0000_1040;
    wait_ar(ok);
    n_checks++;
    if (!ok || araddr !== 32'h0000_1040 || arlen !== 8'd7 || arsize !== 3'd2 || arburst !== 2'b01 || arid !== 4'd1)
      $display("FAIL refill_ar: got ok=%0d addr %h len %0d size %0d burst %0d id %0d required 1 1040 7 2 1 1",
               ok, araddr, arlen, arsize, arburst, arid);
    else n_pass++;
    ar_accept();
    n_checks++;
    if (rready !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL refill_rready: got rready %b busy %b required 1 1", rready, busy_o);
    else n_pass++;
    r_beats(32'h0000_00A0, 8, 1'b1, 2'b00);
    n_checks++;
    if (line_rend_o !== 1'b1 || bus_err_o !== 1'b0)
      $display("FAIL refill_end: got rend %b err %b required 1 0", line_rend_o, bus_err_o);
    else n_pass++;
    n_checks++;
    if (line_rdata_o[31:0] !== 32'hA0 || line_rdata_o[127:96] !== 32'hA3 || line_rdata_o[255:224] !== 32'hA7)
      $display("FAIL refill_data: got w0 %h w3 %h w7 %h required a0 a3 a7",
               line_rdata_o[31:0], line_rdata_o[127:96], line_rdata_o[255:224]);
    else n_pass++;
    line_rreq_i = 1'b0;
    tick();
    n_checks++;
    if (line_rend_o !== 1'b0 || busy_o !== 1'b0 || rready !== 1'b0)
      $display("FAIL refill_after: got rend %b busy %b rready %b required 0 0 0", line_rend_o, busy_o, rready);
    else n_pass++;
  endtask

  task automatic test_uc_write();
    bit ok;
    int unstable = 0;
    uc_wreq_i = 1'b1; addr_i = 32'hBFAF_F000; wen_i = 4'b0011; uc_wdata_i = 32'h1234_5678;
    wait_aw(ok);
    n_checks++;
    if (!ok || awaddr !== 32'hBFAF_F000 || awlen !== 8'd0 || awsize !== 3'd2 || awburst !== 2'b01 || awid !== 4'd1)
      $display("FAIL ucw_aw: got ok=%0d addr %h len %0d size %0d burst %0d id %0d required 1 bfaff000 0 2 1 1",
               ok, awaddr, awlen, awsize, awburst, awid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (awvalid !== 1'b1 || awaddr !== 32'hBFAF_F000 || awlen !== 8'd0) unstable++;
    end
    n_checks++;
    if (unstable != 0) $display("FAIL ucw_aw_stall: got %0d unstable cycles required 0", unstable);
    else n_pass++;
    aw_accept();
    n_checks++;
    if (wvalid !== 1'b1 || wdata !== 32'h1234_5678 || wstrb !== 4'b0011 || wlast !== 1'b1)
      $display("FAIL ucw_w: got valid %b data %h strb %b last %b required 1 12345678 0011 1",
               wvalid, wdata, wstrb, wlast);
    else n_pass++;
    wready = 1'b1; tick(); wready = 1'b0;
    n_checks++;
    if (bready !== 1'b1 || wvalid !== 1'b0 || wend_o !== 1'b0)
      $display("FAIL ucw_b: got bready %b wvalid %b wend %b required 1 0 0", bready, wvalid, wend_o);
    else n_pass++;
    bvalid = 1'b1; bresp = 2'b00; tick(); bvalid = 1'b0;
    n_checks++;
    if (wend_o !== 1'b1 || bus_err_o !== 1'b0)
      $display("FAIL ucw_end: got wend %b err %b required 1 0", wend_o, bus_err_o);
    else n_pass++;
    uc_wreq_i = 1'b0;
    tick();
    n_checks++;
    if (wend_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL ucw_after: got wend %b busy %b required 0 0", wend_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_priority();
    bit ok;
    uc_rreq_i = 1'b1; line_rreq_i = 1'b1; addr_i = 32'h0000_2000;
    wait_ar(ok);
    n_checks++;
    if (!ok || arlen !== 8'd0)
      $display("FAIL prio_first: got ok=%0d arlen %0d required 1 0", ok, arlen);
    else n_pass++;
    ar_accept();
    r_beats(32'h0000_0055, 1, 1'b1, 2'b00);
    n_checks++;
    if (uc_rend_o !== 1'b1 || uc_rdata_o !== 32'h55 || line_rend_o !== 1'b0)
      $display("FAIL prio_uc_end: got ucend %b data %h lend %b required 1 55 0", uc_rend_o, uc_rdata_o, line_rend_o);
    else n_pass++;
    uc_rreq_i = 1'b0;
    tick();
    n_checks++;
    if (arvalid !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL prio_idle_gap: got arvalid %b busy %b required 0 0", arvalid, busy_o);
    else n_pass++;
    tick();
    n_checks++;
    if (arvalid !== 1'b1 || arlen !== 8'd7)
      $display("FAIL prio_second: got arvalid %b arlen %0d required 1 7", arvalid, arlen);
    else n_pass++;
    ar_accept();
    r_beats(32'h0000_00B0, 8, 1'b1, 2'b00);
    n_checks++;
    if (line_rend_o !== 1'b1 || line_rdata_o[255:224] !== 32'hB7)
      $display("FAIL prio_line_end: got rend %b w7 %h required 1 b7", line_rend_o, line_rdata_o[255:224]);
    else n_pass++;
    line_rreq_i = 1'b0;
    tick();
  endtask

  task automatic test_line_write();
    bit ok;
    bit got_last = 1'b0;
    int nbeats = 0, bad_data = 0, bad_last = 0, wend_cnt = 0;
    for (int k = 0; k < 8; k++) line_wdata_i[32*k +: 32] = 32'h10 + 32'(k);
    line_wreq_i = 1'b1; addr_i = 32'h0000_4000;
    wait_aw(ok);
    n_checks++;
    if (!ok || awlen !== 8'd7 || awaddr !== 32'h0000_4000)
      $display("FAIL lw_aw: got ok=%0d awlen %0d addr %h required 1 7 4000", ok, awlen, awaddr);
    else n_pass++;
    aw_accept();
    for (int cyc = 0; cyc < 40; cyc++) begin
      wready = (cyc % 2 == 0);
      if (wvalid && wready) begin
        if (wdata !== 32'h10 + 32'(nbeats) || wstrb !== 4'hF) bad_data++;
        if (wlast !== (nbeats == 7)) bad_last++;
        got_last = wlast;
        nbeats++;
      end
      tick();
      if (got_last) break;
    end
    wready = 1'b0;
    n_checks++;
    if (nbeats != 8 || bad_data != 0 || bad_last != 0)
      $display("FAIL lw_beats: got %0d beats %0d bad data %0d bad last required 8 0 0", nbeats, bad_data, bad_last);
    else n_pass++;
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    if (wend_o) wend_cnt++;
    line_wreq_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wend_o) wend_cnt++;
    end
    n_checks++;
    if (wend_cnt != 1) $display("FAIL lw_wend: got %0d pulses required 1", wend_cnt);
    else n_pass++;
    n_checks++;
    if (line_rdata_o[31:0] !== 32'hB0)
      $display("FAIL lw_rdata_hold: got %h required b0", line_rdata_o[31:0]);
    else n_pass++;
  endtask

  task automatic test_uc_read_err();
    bit ok;
    uc_rreq_i = 1'b1; addr_i = 32'h1FC0_0004;
    wait_ar(ok);
    n_checks++;
    if (!ok || araddr !== 32'h1FC0_0004 || arlen !== 8'd0)
      $display("FAIL ucr_ar: got ok=%0d addr %h len %0d required 1 1fc00004 0", ok, araddr, arlen);
    else n_pass++;
    ar_accept();
    r_beats(32'hDEAD_BEEF, 1, 1'b1, 2'b10);
    n_checks++;
    if (uc_rend_o !== 1'b1 || bus_err_o !== 1'b1 || uc_rdata_o !== 32'hDEAD_BEEF)
      $display("FAIL ucr_err_end: got end %b err %b data %h required 1 1 deadbeef", uc_rend_o, bus_err_o, uc_rdata_o);
    else n_pass++;
    uc_rreq_i = 1'b0;
    tick();
    n_checks++;
    if (bus_err_o !== 1'b0 || uc_rend_o !== 1'b0 || uc_rdata_o !== 32'hDEAD_BEEF)
      $display("FAIL ucr_after: got err %b end %b data %h required 0 0 deadbeef", bus_err_o, uc_rend_o, uc_rdata_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int pulses = 0;
    line_rreq_i = 1'b1; addr_i = 32'h0000_3000;
    wait_ar(ok);
    ar_accept();
    r_beats(32'h0000_00C0, 3, 1'b0, 2'b00);
    n_checks++;
    if (!ok || rready !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL rstmid_pre: got ok=%0d rready %b busy %b required 1 1 1", ok, rready, busy_o);
    else n_pass++;
    rst = 1'b1; tick();
    n_checks++;
    if (rready !== 1'b0 || busy_o !== 1'b0 || arvalid !== 1'b0 || line_rend_o !== 1'b0)
      $display("FAIL rstmid_post: got rready %b busy %b arvalid %b rend %b required 0 0 0 0",
               rready, busy_o, arvalid, line_rend_o);
    else n_pass++;
    rst = 1'b0; line_rreq_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (line_rend_o || busy_o) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL rstmid_quiet: got %0d active cycles required 0", pulses);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line_refill();
    test_uc_write();
    test_priority();
    test_line_write();
    test_uc_read_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
